// File: rtl/player_pkg.sv
// Shared types and constants for the CrossyRobbers player controller.
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_DEAD1   = 3'd2,
    ST_DEAD2   = 3'd3,
    ST_DESPAWN = 3'd4,
    ST_OVER    = 3'd5
  } player_state_e;

  // Bit positions inside a player's {L,R,U,D} key nibble.
  localparam int KEY_L = 3;
  localparam int KEY_R = 2;
  localparam int KEY_U = 1;
  localparam int KEY_D = 0;

  localparam logic [9:0] SPAWN_X_P1 = 10'd292;
  localparam logic [9:0] SPAWN_X_P2 = 10'd516;
  localparam logic [6:0] SCORE_MAX  = 7'd127;
  localparam int         SPRITE_SIZE = 32;

  // Sprite sheet row; game over keeps showing the last death pose row.
  function automatic logic [1:0] anim_row(input player_state_e s);
    case (s)
      ST_WALK:           anim_row = 2'd1;
      ST_DEAD1:          anim_row = 2'd2;
      ST_DEAD2, ST_OVER: anim_row = 2'd3;
      default:           anim_row = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/anim_counter.sv
// Frame/tile animation counter: each tile is held FRAMES_PER_TILE frames, tile wraps at TILES.
// wrap_o flags the frame whose edge returns the counter to tile 0.
module anim_counter #(
  parameter int FRAMES_PER_TILE = 5,
  parameter int TILES           = 8,
  localparam int FW  = (FRAMES_PER_TILE > 1) ? $clog2(FRAMES_PER_TILE) : 1,
  localparam int TAW = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [TAW-1:0] tile_o,
  output logic           wrap_o
);

  logic [FW-1:0]  frame_q, frame_d;
  logic [TAW-1:0] tile_q, tile_d;
  logic           frame_last, tile_last;

  assign frame_last = (frame_q == FW'(FRAMES_PER_TILE - 1));
  assign tile_last  = (tile_q == TAW'(TILES - 1));
  // Independent of clr_i so a consumer may clear in response to the wrap.
  assign wrap_o     = en_i & frame_last & tile_last;
  assign tile_o     = tile_q;

  always_comb begin
    frame_d = frame_q;
    tile_d  = tile_q;
    if (clr_i) begin
      frame_d = '0;
      tile_d  = '0;
    end else if (en_i) begin
      if (frame_last) begin
        frame_d = '0;
        tile_d  = tile_last ? '0 : tile_q + 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      tile_q  <= '0;
    end else begin
      frame_q <= frame_d;
      tile_q  <= tile_d;
    end
  end

endmodule

// File: rtl/player_unit.sv
// Per-player controller: spawn, movement, animation, items, lives, invulnerability, score.
// All state advances once per FrameClk; pixel outputs are combinational from registers + DrawX/Y.
module player_unit
  import player_pkg::*;
#(
  parameter int MAX_ITEMS       = 3,
  parameter int TILES_PER_ANIM  = 8,
  parameter int FRAMES_PER_TILE = 5,
  parameter int LIVES           = 3,
  parameter int INVULN_FRAMES   = 120,
  parameter int MOVE_DIV        = 2,
  parameter int MIN_X           = 100,
  parameter int MAX_X           = 739,
  parameter int MIN_Y           = 65,
  parameter int MAX_Y           = 448,
  parameter int SPAWN_Y         = 400,
  localparam int TW = $clog2(4 * TILES_PER_ANIM * (MAX_ITEMS + 1))
) (
  input  logic          FrameClk,
  input  logic          Reset,
  input  logic          SpawnEnable,
  input  logic          PlayerOne,
  input  logic          PlayerHit,
  input  logic [1:0]    PlayerCollect,
  input  logic          Deposit,
  input  logic [2:0]    Speed,
  input  logic [7:0]    Keycode,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  output logic          Collected,
  output logic [2:0]    Dropped,
  output logic          PlayerPixel,
  output logic          PlayerPriority,
  output logic [TW-1:0] Tile,
  output logic [4:0]    PixelX,
  output logic [4:0]    PixelY,
  output logic [4:0]    HbOffset,
  output logic [6:0]    Score,
  output logic [1:0]    Lives,
  output logic          GameOver,
  output logic [9:0]    PlayerX,
  output logic [9:0]    PlayerY,
  output player_state_e StateDbg
);

  localparam int IW  = $clog2(MAX_ITEMS + 1);
  localparam int INW = ($clog2(INVULN_FRAMES + 1) > 4) ? $clog2(INVULN_FRAMES + 1) : 4;
  localparam int DW  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int TAW = (TILES_PER_ANIM > 1) ? $clog2(TILES_PER_ANIM) : 1;

  player_state_e  state_q, state_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic           face_left_q, face_left_d;
  logic [IW-1:0]  items_q, items_d;
  logic [2:0]     val_q, val_d;
  logic [6:0]     score_q, score_d;
  logic [1:0]     lives_q, lives_d;
  logic           over_q, over_d;
  logic [INW-1:0] invuln_q, invuln_d;
  logic [DW-1:0]  div_q, div_d;
  logic           collected_q, collected_d;
  logic [2:0]     dropped_q, dropped_d;

  logic           alive, div_last, spawn, anim_clr, anim_en, anim_wrap;
  logic [TAW-1:0] anim_tile;
  logic [3:0]     key;
  logic           mv_x, mv_y;
  logic [2:0]     step;
  logic [10:0]    x_ext, y_ext, step_ext;
  logic [9:0]     x_dec, x_inc, y_dec, y_inc;
  logic [3:0]     val_sum;
  logic [7:0]     score_sum;

  assign alive    = (state_q == ST_IDLE) || (state_q == ST_WALK);
  assign div_last = (div_q == DW'(MOVE_DIV - 1));
  assign anim_en  = alive || (state_q == ST_DEAD1) || (state_q == ST_DEAD2);
  assign key      = PlayerOne ? Keycode[7:4] : Keycode[3:0];
  assign mv_x     = key[KEY_L] ^ key[KEY_R];
  assign mv_y     = key[KEY_U] ^ key[KEY_D];

  // Each carried item slows the player, but a non-zero speed never drops below 1 px.
  always_comb begin
    if (Speed == 3'd0)              step = 3'd0;
    else if (Speed > 3'(items_q))   step = Speed - 3'(items_q);
    else                            step = 3'd1;
  end

  assign x_ext    = {1'b0, x_q};
  assign y_ext    = {1'b0, y_q};
  assign step_ext = 11'(step);
  assign x_dec = (x_ext < 11'(MIN_X) + step_ext) ? 10'(MIN_X) : 10'(x_ext - step_ext);
  assign x_inc = (x_ext + step_ext > 11'(MAX_X)) ? 10'(MAX_X) : 10'(x_ext + step_ext);
  assign y_dec = (y_ext < 11'(MIN_Y) + step_ext) ? 10'(MIN_Y) : 10'(y_ext - step_ext);
  assign y_inc = (y_ext + step_ext > 11'(MAX_Y)) ? 10'(MAX_Y) : 10'(y_ext + step_ext);

  // Carried value saturates at 7 so it always fits the Dropped report.
  assign val_sum   = {1'b0, val_q} + 4'(PlayerCollect);
  assign score_sum = {1'b0, score_q} + 8'(val_q);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    face_left_d = face_left_q;
    items_d     = items_q;
    val_d       = val_q;
    score_d     = score_q;
    lives_d     = lives_q;
    over_d      = over_q;
    invuln_d    = (invuln_q != '0) ? invuln_q - 1'b1 : invuln_q;
    div_d       = div_q;
    collected_d = 1'b0;
    dropped_d   = 3'd0;
    anim_clr    = 1'b0;
    spawn       = 1'b0;
    if (!SpawnEnable) begin
      state_d  = ST_DESPAWN;
      items_d  = '0;
      val_d    = 3'd0;
      score_d  = 7'd0;
      lives_d  = 2'(LIVES);
      over_d   = 1'b0;
      invuln_d = '0;
      div_d    = '0;
      anim_clr = 1'b1;
    end else begin
      case (state_q)
        ST_DESPAWN: spawn = 1'b1;
        ST_IDLE, ST_WALK: begin
          div_d = div_last ? '0 : div_q + 1'b1;
          if (PlayerHit && invuln_q == '0) begin
            state_d   = ST_DEAD1;
            anim_clr  = 1'b1;
            lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            dropped_d = val_q;
            items_d   = '0;
            val_d     = 3'd0;
          end else begin
            if (PlayerCollect != 2'd0 && items_q < IW'(MAX_ITEMS)) begin
              items_d     = items_q + 1'b1;
              val_d       = (val_sum > 4'd7) ? 3'd7 : val_sum[2:0];
              collected_d = 1'b1;
            end else if (Deposit && PlayerCollect == 2'd0) begin
              score_d = (score_sum > 8'(SCORE_MAX)) ? SCORE_MAX : score_sum[6:0];
              items_d = '0;
              val_d   = 3'd0;
            end
            if (div_last) begin
              if (mv_x) begin
                x_d         = key[KEY_L] ? x_dec : x_inc;
                face_left_d = key[KEY_L];
              end
              if (mv_y) y_d = key[KEY_U] ? y_dec : y_inc;
              state_d = (mv_x || mv_y) ? ST_WALK : ST_IDLE;
            end
          end
        end
        ST_DEAD1: if (anim_wrap) state_d = ST_DEAD2;
        ST_DEAD2: begin
          if (anim_wrap) begin
            if (lives_q == 2'd0) begin
              state_d  = ST_OVER;
              over_d   = 1'b1;
              anim_clr = 1'b1;
            end else begin
              spawn = 1'b1;
            end
          end
        end
        ST_OVER: anim_clr = 1'b1;
        default: state_d = ST_DESPAWN;
      endcase
      if (spawn) begin
        state_d     = ST_IDLE;
        x_d         = PlayerOne ? SPAWN_X_P1 : SPAWN_X_P2;
        y_d         = 10'(SPAWN_Y);
        face_left_d = !PlayerOne;
        invuln_d    = INW'(INVULN_FRAMES);
        div_d       = '0;
        anim_clr    = 1'b1;
      end
    end
  end

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_DESPAWN;
      x_q         <= 10'(MIN_X);
      y_q         <= 10'(MIN_Y);
      face_left_q <= 1'b0;
      items_q     <= '0;
      val_q       <= 3'd0;
      score_q     <= 7'd0;
      lives_q     <= 2'(LIVES);
      over_q      <= 1'b0;
      invuln_q    <= '0;
      div_q       <= '0;
      collected_q <= 1'b0;
      dropped_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      face_left_q <= face_left_d;
      items_q     <= items_d;
      val_q       <= val_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      over_q      <= over_d;
      invuln_q    <= invuln_d;
      div_q       <= div_d;
      collected_q <= collected_d;
      dropped_q   <= dropped_d;
    end
  end

  anim_counter #(
    .FRAMES_PER_TILE(FRAMES_PER_TILE),
    .TILES          (TILES_PER_ANIM)
  ) u_anim (
    .clk_i (FrameClk),
    .rst_i (Reset),
    .clr_i (anim_clr),
    .en_i  (anim_en),
    .tile_o(anim_tile),
    .wrap_o(anim_wrap)
  );

  logic       in_x, in_y, blink, visible;
  logic [4:0] dx, dy;

  assign in_x = ({1'b0, DrawX} >= x_ext) && ({1'b0, DrawX} < x_ext + 11'(SPRITE_SIZE));
  assign in_y = ({1'b0, DrawY} >= y_ext) && ({1'b0, DrawY} < y_ext + 11'(SPRITE_SIZE));
  assign dx   = DrawX[4:0] - x_q[4:0];
  assign dy   = DrawY[4:0] - y_q[4:0];
  // Blink: hidden on every other 8-frame window while invulnerable.
  assign blink   = (invuln_q != '0) && invuln_q[3];
  assign visible = (state_q != ST_DESPAWN) && (state_q != ST_OVER) && !blink;

  assign PlayerPixel    = in_x && in_y && visible;
  assign PlayerPriority = PlayerPixel && !dy[4];
  assign PixelX         = face_left_q ? ~dx : dx;
  assign PixelY         = dy;
  assign HbOffset       = face_left_q ? 5'd0 : 5'd16;
  assign Tile = TW'(anim_row(state_q)) * TW'(TILES_PER_ANIM * (MAX_ITEMS + 1))
              + TW'(anim_tile) * TW'(MAX_ITEMS + 1) + TW'(items_q);

  assign Collected = collected_q;
  assign Dropped   = dropped_q;
  assign Score     = score_q;
  assign Lives     = lives_q;
  assign GameOver  = over_q;
  assign PlayerX   = x_q;
  assign PlayerY   = y_q;
  assign StateDbg  = state_q;

endmodule
